csa_tree_pipe: RTL and testbench
================================

Name: csa_tree_pipe

Overview:
- Parametrised, pipelined successor to the 24-bit 7:2 carry-save compressor.
- Reduces NUM_OPS operands of WIDTH bits to a sum/carry pair.
- Supports lane segmentation for multi-precision modes: 1 full lane, 2 half lanes, or 4 quarter lanes. No carry crosses a lane boundary.
- Sits between the partial-product generator and the final carry-propagate adder in the PE. Has a valid/ready handshake on both sides and a synchronous flush.

Parameters:
- WIDTH, 24: operand and result width. Must be a multiple of 4 (elaboration error otherwise).
- NUM_OPS, 7: number of operands. Legal range 3..16.
- PIPE_STAGES, 2: register stages from input to output. Legal range 1..4. Equals the latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all in-flight transactions.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept the input transaction.
- in_mode  in  2  precision mode: 0 = one WIDTH lane; 1 = two WIDTH/2 lanes; 2 = four WIDTH/4 lanes; 3 = reserved, handled as 0.
- in_ops  in  NUM_OPS*WIDTH  flat operand bus. Operand k occupies [k*WIDTH +: WIDTH].
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts the output.
- out_mode  out  2  mode travelling with the transaction. Reserved value 3 is emitted as 0.
- out_sum  out  WIDTH  carry-save sum vector.
- out_carry  out  WIDTH  carry vector, already weight-aligned (bit i has weight 2^i).
- mode_err  out  1  registered sticky flag, set when a transaction with in_mode==3 is accepted.

Behaviour:
- Arithmetic contract, per lane L of width LW:
  - (out_sum_L + out_carry_L) mod 2^LW == (sum of all operand_L slices) mod 2^LW.
  - out_carry bit at each lane LSB is 0.
  - Carries out of a lane MSB are discarded and never enter the next lane.
- Internal tree structure is free (7:2 / 4:2 / 3:2 cells in any mix), provided the contract holds for every NUM_OPS and mode.
- Reduction logic may be distributed across the PIPE_STAGES register boundaries. Mode is registered alongside data at every stage.
- Transfers:
  - Input transfer occurs when in_valid && in_ready at a rising edge.
  - Output transfer occurs when out_valid && out_ready.
- Pipeline control:
  - Each stage holds a valid bit. Stage s loads from stage s-1 when stage s is empty or is being drained in the same cycle.
  - in_ready = !flush && (stage0 empty || stage0 advancing). The combinational ready chain from out_ready is permitted.
  - Bubbles collapse: an empty stage never blocks an upstream stage.
- Latency and throughput:
  - With out_ready held high, a transaction accepted at edge n appears with out_valid=1 after edge n+PIPE_STAGES-1. Latency is PIPE_STAGES cycles from the accept cycle.
  - Throughput is 1 transaction per cycle.
- Backpressure:
  - out_ready=0 with out_valid=1 holds out_sum/out_carry/out_mode stable until transfer.
  - The pipeline fills completely, after which in_ready drops to 0.
  - No transaction is lost or duplicated.
- Flush:
  - On the rising edge with flush=1, all stage valid bits clear. Any input presented in that cycle is not accepted, since in_ready=0.
  - out_valid=0 from the next cycle. Data registers are don't-care after flush.
  - Flush does not clear mode_err.
- Reset (asynchronous, rst_n low):
  - All valid bits, out_valid, out_sum, out_carry, out_mode and mode_err go to 0 immediately.
  - In-flight transactions are discarded.
  - in_ready = 1 after reset release, when flush=0.
- Simultaneous output drain and input accept on a full pipeline: both transfers occur and occupancy is unchanged.
- Mode changes between back-to-back transactions need no bubble. Each transaction uses its own mode.

Test Plan:
- WIDTH=24, NUM_OPS=7, all operands 0xFFFFFF, mode 0 -> out_sum+out_carry (mod 2^24) = 0xFFFFF9, out_valid exactly PIPE_STAGES cycles after accept.
- Same operands, mode 1 -> lane results 0xFF9/0xFF9 (packed 0xFF9FF9); out_carry[0]=out_carry[12]=0. Mode 2 -> each 6-bit lane 0x39 (packed 0xE79E79).
- Stream of 20 random transactions with random modes, out_ready toggled pseudo-randomly -> every result matches the scoreboard in order, no drops or duplicates, outputs stable while stalled.
- Fill pipeline with out_ready=0 -> in_ready=0 after PIPE_STAGES accepts. Then raise out_ready with in_valid=1 -> simultaneous accept and drain every cycle.
- Assert flush with 2 transactions in flight and in_valid=1 -> out_valid=0 next cycle, the flushed input is not accepted, and the next accepted transaction is correct.
- Mode 3 transaction -> processed as mode 0, out_mode=0, mode_err=1 and sticky. Assert rst_n low mid-stream -> all outputs 0 asynchronously, and mode_err clears.

Source files
------------

// File: rtl/csa_tree_pipe.sv
// csa_tree_pipe: lane-segmented carry-save reduction of NUM_OPS operands to a
// sum/carry pair, behind a PIPE_STAGES-deep valid/ready pipeline with flush.
module csa_tree_pipe #(
  parameter int WIDTH       = 24,
  parameter int NUM_OPS     = 7,
  parameter int PIPE_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_mode,
  input  logic [NUM_OPS*WIDTH-1:0]   in_ops,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_mode,
  output logic [WIDTH-1:0]           out_sum,
  output logic [WIDTH-1:0]           out_carry,
  output logic                       mode_err
);

  localparam int QW = WIDTH / 4;

  if ((WIDTH % 4) != 0) begin : g_chk_width
    $error("csa_tree_pipe: WIDTH must be a multiple of 4");
  end
  if ((NUM_OPS < 3) || (NUM_OPS > 16)) begin : g_chk_ops
    $error("csa_tree_pipe: NUM_OPS must be in 3..16");
  end
  if ((PIPE_STAGES < 1) || (PIPE_STAGES > 4)) begin : g_chk_stages
    $error("csa_tree_pipe: PIPE_STAGES must be in 1..4");
  end

  typedef enum logic [1:0] {
    MODE_FULL    = 2'd0,
    MODE_HALF    = 2'd1,
    MODE_QUARTER = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  mode_e                  mode_n;
  logic [WIDTH-1:0]       lsb_mask;
  logic [WIDTH-1:0]       red_sum;
  logic [WIDTH-1:0]       red_carry;
  logic [WIDTH-1:0]       cur_op;
  logic [WIDTH-1:0]       maj;

  logic [PIPE_STAGES-1:0] vld;
  logic [PIPE_STAGES-1:0] load;
  logic                   ready_acc;
  logic                   accept;

  logic [WIDTH-1:0]       sum_q   [PIPE_STAGES];
  logic [WIDTH-1:0]       carry_q [PIPE_STAGES];
  logic [1:0]             mode_q  [PIPE_STAGES];

  // Normalise the mode (reserved -> full lane) and mark every lane LSB position
  always_comb begin
    mode_n = mode_e'(in_mode);
    if (mode_n == MODE_RSVD) mode_n = MODE_FULL;
    lsb_mask    = '0;
    lsb_mask[0] = 1'b1;
    case (mode_n)
      MODE_HALF: lsb_mask[WIDTH/2] = 1'b1;
      MODE_QUARTER: begin
        lsb_mask[QW]   = 1'b1;
        lsb_mask[2*QW] = 1'b1;
        lsb_mask[3*QW] = 1'b1;
      end
      default: ;
    endcase
  end

  // 3:2 compressor chain; shifted carries are cut at every lane LSB so
  // nothing leaves a lane MSB or enters the neighbouring lane
  always_comb begin
    red_sum   = in_ops[0 +: WIDTH];
    red_carry = in_ops[WIDTH +: WIDTH];
    cur_op    = '0;
    maj       = '0;
    for (int unsigned k = 2; k < NUM_OPS; k++) begin
      cur_op    = in_ops[k*WIDTH +: WIDTH];
      maj       = (red_sum & red_carry) | (red_sum & cur_op) | (red_carry & cur_op);
      red_sum   = red_sum ^ red_carry ^ cur_op;
      red_carry = (maj << 1) & ~lsb_mask;
    end
  end

  // Ready chain: a stage may load when it, or any stage downstream, has room,
  // or the output is being drained; evaluated from the output backwards
  always_comb begin
    load      = '0;
    ready_acc = out_ready;
    for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
      ready_acc = ready_acc | ~vld[PIPE_STAGES-1-i];
      load[PIPE_STAGES-1-i] = ready_acc;
    end
  end

  assign in_ready = ~flush & load[0];
  assign accept   = in_valid & in_ready;

  // Stage valid bits, data/mode registers and the sticky reserved-mode flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld      <= '0;
      mode_err <= 1'b0;
      for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
        sum_q[s]   <= '0;
        carry_q[s] <= '0;
        mode_q[s]  <= '0;
      end
    end else begin
      if (accept && (mode_e'(in_mode) == MODE_RSVD)) mode_err <= 1'b1;

      if (flush) begin
        vld <= '0;
      end else begin
        if (load[0]) vld[0] <= accept;
        for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
          if (load[s]) vld[s] <= vld[s-1];
        end
      end

      if (accept) begin
        sum_q[0]   <= red_sum;
        carry_q[0] <= red_carry;
        mode_q[0]  <= mode_n;
      end
      for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
        if (load[s] && vld[s-1]) begin
          sum_q[s]   <= sum_q[s-1];
          carry_q[s] <= carry_q[s-1];
          mode_q[s]  <= mode_q[s-1];
        end
      end
    end
  end

  assign out_valid = vld[PIPE_STAGES-1];
  assign out_sum   = sum_q[PIPE_STAGES-1];
  assign out_carry = carry_q[PIPE_STAGES-1];
  assign out_mode  = mode_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_csa_tree_pipe.sv
// tb_csa_tree_pipe: randomized and directed stimulus with a queue scoreboard;
// expected results come from lane-wise modular addition of the operands.
module tb_csa_tree_pipe;

  localparam int W  = 24;
  localparam int N  = 7;
  localparam int P  = 2;
  localparam int QW = W / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_mode = '0;
  logic [N*W-1:0]   in_ops = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:0]       out_mode;
  logic [W-1:0]     out_sum;
  logic [W-1:0]     out_carry;
  logic             mode_err;

  csa_tree_pipe #(.WIDTH(W), .NUM_OPS(N), .PIPE_STAGES(P)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_ops(in_ops),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .out_sum(out_sum), .out_carry(out_carry), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] val;
  } exp_t;

  exp_t         sbq[$];
  int           passed = 0;
  int           total = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  int           last_pop_cyc = 0;
  int           n_out = 0;
  int           rdy_pol = 2;   // 0 always ready, 1 random, 2 never ready
  logic         mon_en = 1'b0;
  logic         ovalid_at_acc = 1'b0;
  logic         stall_pending = 1'b0;
  logic [W-1:0] held_sum, held_carry;
  logic [1:0]   held_mode;
  logic [W-1:0] last_res, last_carry;
  logic [1:0]   last_mode;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Lane-wise modular addition: each lane wraps independently
  function automatic logic [W-1:0] lane_add(input logic [1:0] mode, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    int lw;
    logic [63:0] m, x;
    logic [W-1:0] r;
    lw = (mode == 2'd1) ? W/2 : (mode == 2'd2) ? QW : W;
    m  = (64'd1 << lw) - 64'd1;
    r  = '0;
    for (int base = 0; base < W; base += lw) begin
      x = ((64'(a) >> base) & m) + ((64'(b) >> base) & m);
      r = r | W'((x & m) << base);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] ref_model(input logic [1:0] mode, input logic [N*W-1:0] ops);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r = lane_add(mode, r, ops[k*W +: W]);
    return r;
  endfunction

  function automatic logic [3:0] lsb_bits(input logic [1:0] mode, input logic [W-1:0] c);
    logic [3:0] b;
    b = '0;
    b[0] = c[0];
    if (mode == 2'd1) b[1] = c[W/2];
    if (mode == 2'd2) begin
      b[1] = c[QW];
      b[2] = c[2*QW];
      b[3] = c[3*QW];
    end
    return b;
  endfunction

  function automatic logic [N*W-1:0] rand_ops();
    logic [N*W-1:0] o;
    for (int k = 0; k < N; k++) o[k*W +: W] = W'($urandom);
    return o;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready policy
  initial forever begin
    @(negedge clk);
    case (rdy_pol)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: checks held outputs during stalls, pops on every output transfer
  initial forever begin
    @(negedge clk);
    #2;
    if (mon_en && rst_n) begin
      if (stall_pending) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {out_mode, out_sum, out_carry}, {held_mode, held_sum, held_carry});
        stall_pending = 1'b0;
      end
      if (flush) begin
        sbq.delete();
      end else if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("spurious_output", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          last_res   = lane_add(e.mode, out_sum, out_carry);
          last_carry = out_carry;
          last_mode  = out_mode;
          check("out_mode", out_mode, e.mode);
          check("lane_result", last_res, e.val);
          check("carry_lane_lsb", lsb_bits(e.mode, out_carry), 0);
        end
        n_out++;
        last_pop_cyc = cyc;
      end else if (out_valid) begin
        stall_pending = 1'b1;
        held_sum   = out_sum;
        held_carry = out_carry;
        held_mode  = out_mode;
      end
    end
  end

  task automatic send(input logic [N*W-1:0] ops, input logic [1:0] mode, output int waits);
    exp_t e;
    waits = 0;
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    in_ops   = ops;
    in_mode  = mode;
    #1;
    while (!in_ready && waits < 300) begin
      @(negedge clk);
      #2;
      waits++;
    end
    if (in_ready) begin
      e.mode = (mode == 2'd3) ? 2'd0 : mode;
      e.val  = ref_model(e.mode, ops);
      sbq.push_back(e);
      acc_cyc = cyc + 1;
      ovalid_at_acc = out_valid;
    end else begin
      check("accept_timeout", 0, 1);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 500 && sbq.size() != 0; t++) begin
      @(negedge clk);
      #3;
    end
    check("drain", sbq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N*W-1:0] ones;
    int w;
    int n_before;
    ones = '1;

    // Reset state
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {out_mode, out_sum, out_carry}, 0);
    check("rst_mode_err", mode_err, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    mon_en = 1'b1;

    // All-ones operands in each mode, with latency measured in mode 0
    rdy_pol = 0;
    send(ones, 2'd0, w);
    idle();
    wait_drain();
    check("latency", last_pop_cyc - acc_cyc + 1, P);
    check("m0_result", last_res, 24'hFFFFF9);
    send(ones, 2'd1, w);
    idle();
    wait_drain();
    check("m1_result", last_res, 24'hFF9FF9);
    check("m1_carry_lsb", {last_carry[W/2], last_carry[0]}, 0);
    send(ones, 2'd2, w);
    idle();
    wait_drain();
    check("m2_result", last_res, 24'hE79E79);

    // Random stream with random backpressure
    rdy_pol = 1;
    n_before = n_out;
    for (int i = 0; i < 20; i++) begin
      send(rand_ops(), 2'($urandom_range(0, 2)), w);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    wait_drain();
    check("stream_count", n_out - n_before, 20);
    check("mode_err_clear", mode_err, 0);

    // Fill with no downstream ready, then stream through a full pipeline
    rdy_pol = 2;
    for (int i = 0; i < P; i++) send(rand_ops(), 2'($urandom_range(0, 2)), w);
    @(negedge clk);
    #1;
    in_ops = rand_ops();
    #1;
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    rdy_pol = 0;
    for (int i = 0; i < 4; i++) begin
      send(rand_ops(), 2'($urandom_range(0, 2)), w);
      check("full_accept_wait", w, 0);
      check("full_drain_same_cycle", ovalid_at_acc, 1);
    end
    idle();
    wait_drain();

    // Flush with transactions in flight and an input offered
    rdy_pol = 2;
    for (int i = 0; i < 2; i++) send(rand_ops(), 2'($urandom_range(0, 2)), w);
    @(negedge clk);
    #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_ops   = rand_ops();
    #1;
    check("flush_in_ready", in_ready, 0);
    @(negedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_out_valid", out_valid, 0);
    rdy_pol = 0;
    n_before = n_out;
    send(rand_ops(), 2'd1, w);
    idle();
    wait_drain();
    check("flush_post_count", n_out - n_before, 1);

    // Reserved mode: handled as full lane, sticky error flag
    send(ones, 2'd3, w);
    idle();
    wait_drain();
    check("m3_result", last_res, 24'hFFFFF9);
    check("m3_out_mode", last_mode, 0);
    check("mode_err_set", mode_err, 1);
    @(negedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    #1;
    flush = 1'b0;
    check("mode_err_after_flush", mode_err, 1);
    send(rand_ops(), 2'd0, w);
    idle();
    wait_drain();
    check("mode_err_sticky", mode_err, 1);

    // Asynchronous reset mid-stream
    rdy_pol = 2;
    for (int i = 0; i < 2; i++) send(ones, 2'd2, w);
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    mon_en   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_outputs", {out_mode, out_sum, out_carry}, 0);
    check("arst_mode_err", mode_err, 0);
    sbq.delete();
    stall_pending = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1);
    mon_en  = 1'b1;
    rdy_pol = 0;
    send(rand_ops(), 2'd2, w);
    idle();
    wait_drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
